// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
//   rf_aw()      : address width for a given register count
//   rf_addr_t    : register address at the default 32-entry size
//   rf_data_t    : register data at the default 32-bit width
//   RF_ZERO_ADDR : index of the hardwired-zero register
package regfile_pkg;

  localparam int unsigned RF_DEFAULT_AW     = 5;
  localparam int unsigned RF_DEFAULT_DATA_W = 32;
  localparam int unsigned RF_ZERO_ADDR      = 0;

  typedef logic [RF_DEFAULT_AW-1:0]     rf_addr_t;
  typedef logic [RF_DEFAULT_DATA_W-1:0] rf_data_t;

  function automatic int unsigned rf_aw(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for regfile_mp.
// Ports:
//   clk_i, reset_ni            : clock, synchronous active-low reset
//   wren_i, waddr_i            : writeback enables/addresses (release busy)
//   alloc_en_i, alloc_addr_i   : issue-stage allocation (set busy)
//   busy_o                     : current busy vector
//   busy_next_o                : next-state busy vector (used for bypass)
//   busy_cnt_o                 : registered popcount of the busy vector
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_WR   = 2,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = rf_aw(NUM_REGS),
  localparam int unsigned CW      = $clog2(NUM_REGS + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [NUM_WR-1:0]          wren_i,
  input  logic [NUM_WR-1:0][AW-1:0]  waddr_i,
  input  logic                       alloc_en_i,
  input  logic [AW-1:0]              alloc_addr_i,
  output logic [NUM_REGS-1:0]        busy_o,
  output logic [NUM_REGS-1:0]        busy_next_o,
  output logic [CW-1:0]              busy_cnt_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  // Clear on writeback first, then set on alloc so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wren_i[k]) busy_d[waddr_i[k]] = 1'b0;
    end
    if (alloc_en_i) busy_d[alloc_addr_i] = 1'b1;
    if (ZERO_REG) busy_d[RF_ZERO_ADDR] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d = cnt_d + CW'(busy_d[r]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o      = busy_q;
  assign busy_next_o = busy_d;
  assign busy_cnt_o  = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with busy scoreboard.
// Ports:
//   i_clk, i_reset_n           : clock, synchronous active-low reset
//   i_rs_addr / o_rs_data      : NUM_RD asynchronous read ports
//   o_rs_busy                  : busy bit of each read address
//   i_rd_wren/addr/data        : NUM_WR synchronous write ports, highest index wins
//   i_alloc_en, i_alloc_addr   : mark a destination register busy
//   o_busy_cnt                 : registered count of busy registers
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = rf_aw(NUM_REGS),
  localparam int unsigned CW      = $clog2(NUM_REGS + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [NUM_RD-1:0][AW-1:0]     i_rs_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0] o_rs_data,
  output logic [NUM_RD-1:0]             o_rs_busy,
  input  logic [NUM_WR-1:0]             i_rd_wren,
  input  logic [NUM_WR-1:0][AW-1:0]     i_rd_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0] i_rd_data,
  input  logic                          i_alloc_en,
  input  logic [AW-1:0]                 i_alloc_addr,
  output logic [CW-1:0]                 o_busy_cnt
);

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [DATA_W-1:0]   mem_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;

  function automatic logic is_zero_addr(input logic [AW-1:0] a);
    return ZERO_REG && (a == AW'(RF_ZERO_ADDR));
  endfunction

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i        (i_clk),
    .reset_ni     (i_reset_n),
    .wren_i       (i_rd_wren),
    .waddr_i      (i_rd_addr),
    .alloc_en_i   (i_alloc_en),
    .alloc_addr_i (i_alloc_addr),
    .busy_o       (busy_q),
    .busy_next_o  (busy_d),
    .busy_cnt_o   (o_busy_cnt)
  );

  // Ascending port order: a later (higher) port overwrites an earlier one.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (i_rd_wren[k] && !is_zero_addr(i_rd_addr[k])) begin
        mem_d[i_rd_addr[k]] = i_rd_data[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      mem_q[r] <= !i_reset_n ? '0 : mem_d[r];
    end
  end

  // Bypassed busy comes from the next-state vector: the matching write clears
  // it unless a same-cycle alloc sets it again.
  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      o_rs_data[j] = mem_q[i_rs_addr[j]];
      o_rs_busy[j] = busy_q[i_rs_addr[j]];
      if (BYPASS && i_reset_n) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (i_rd_wren[k] && (i_rd_addr[k] == i_rs_addr[j])) begin
            o_rs_data[j] = i_rd_data[k];
            o_rs_busy[j] = busy_d[i_rs_addr[j]];
          end
        end
      end
      if (is_zero_addr(i_rs_addr[j])) begin
        o_rs_data[j] = '0;
        o_rs_busy[j] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  typedef struct {
    string       name;
    logic        rst_n;
    logic [1:0]  wren;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        aen;
    logic [4:0]  aaddr;
    logic [4:0]  ra0, ra1;
    logic [31:0] ed0, ed1;
    logic [1:0]  ebusy;
    logic [5:0]  ecnt;
    logic [31:0] enb0;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] ed0, ed1;
    logic [1:0]  ebusy;
    logic [5:0]  ecnt;
    logic [31:0] enb0;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0][4:0]  rs_addr;
  logic [1:0][31:0] rs_data, nb_data;
  logic [1:0]       rs_busy, nb_busy;
  logic [1:0]       wren;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic             alloc_en;
  logic [4:0]       alloc_addr;
  logic [5:0]       busy_cnt, nb_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1'b1)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_rs_addr    (rs_addr),
    .o_rs_data    (rs_data),
    .o_rs_busy    (rs_busy),
    .i_rd_wren    (wren),
    .i_rd_addr    (wr_addr),
    .i_rd_data    (wr_data),
    .i_alloc_en   (alloc_en),
    .i_alloc_addr (alloc_addr),
    .o_busy_cnt   (busy_cnt)
  );

  regfile_mp #(.BYPASS(1'b0)) dut_nb (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_rs_addr    (rs_addr),
    .o_rs_data    (nb_data),
    .o_rs_busy    (nb_busy),
    .i_rd_wren    (wren),
    .i_rd_addr    (wr_addr),
    .i_rd_data    (wr_data),
    .i_alloc_en   (alloc_en),
    .i_alloc_addr (alloc_addr),
    .o_busy_cnt   (nb_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic rst_n_v, input logic [1:0] w,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic ae, input logic [4:0] aa,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [1:0] eb, input logic [5:0] ec,
                              input logic [31:0] en);
    vec_t v;
    v = '{name, rst_n_v, w, a0, a1, d0, d1, ae, aa, r0, r1, e0, e1, eb, ec, en};
    return v;
  endfunction

  // Drive after the rising edge, score at the falling edge, commit on the next rise.
  task automatic run_vec(input vec_t v);
    exp_t e;
    rst_n      = v.rst_n;
    wren       = v.wren;
    wr_addr[0] = v.wa0;
    wr_addr[1] = v.wa1;
    wr_data[0] = v.wd0;
    wr_data[1] = v.wd1;
    alloc_en   = v.aen;
    alloc_addr = v.aaddr;
    rs_addr[0] = v.ra0;
    rs_addr[1] = v.ra1;
    sb.push_back('{v.name, v.ed0, v.ed1, v.ebusy, v.ecnt, v.enb0});
    @(negedge clk);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got 1 expected 0 underflow", v.name);
    end else begin
      e = sb.pop_front();
      chk({e.name, ".data0"}, rs_data[0], e.ed0);
      chk({e.name, ".data1"}, rs_data[1], e.ed1);
      chk({e.name, ".busy"}, {30'd0, rs_busy}, {30'd0, e.ebusy});
      chk({e.name, ".cnt"}, {26'd0, busy_cnt}, {26'd0, e.ecnt});
      chk({e.name, ".nb_data0"}, nb_data[0], e.enb0);
      chk({e.name, ".nb_cnt"}, {26'd0, nb_cnt}, {26'd0, e.ecnt});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wren = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; rs_addr = '0;
    @(posedge clk);
    #1;

    //           name            rst wren wa0 wa1 wd0            wd1            aen aa  ra0 ra1 ed0            ed1            busy   cnt nb0
    vecs.push_back(mk("reset_read",   1, 2'b00, 0,  0, 0,             0,             0, 0,  5, 31, 0,             0,             2'b00, 0, 0));
    vecs.push_back(mk("dual_write",   1, 2'b11, 3,  7, 32'h1111_2222, 32'hDEAD_BEEF, 0, 0,  3,  7, 32'h1111_2222, 32'hDEAD_BEEF, 2'b00, 0, 0));
    vecs.push_back(mk("read_3_7",     1, 2'b00, 0,  0, 0,             0,             0, 0,  3,  7, 32'h1111_2222, 32'hDEAD_BEEF, 2'b00, 0, 32'h1111_2222));
    vecs.push_back(mk("collide_9",    1, 2'b11, 9,  9, 32'hA,         32'hB,         0, 0,  9,  0, 32'hB,         0,             2'b00, 0, 0));
    vecs.push_back(mk("read_9",       1, 2'b00, 0,  0, 0,             0,             0, 0,  9,  3, 32'hB,         32'h1111_2222, 2'b00, 0, 32'hB));
    vecs.push_back(mk("write_x0",     1, 2'b01, 0,  0, 32'hFFFF_FFFF, 0,             0, 0,  0,  9, 0,             32'hB,         2'b00, 0, 0));
    vecs.push_back(mk("read_x0",      1, 2'b00, 0,  0, 0,             0,             0, 0,  0,  9, 0,             32'hB,         2'b00, 0, 0));
    vecs.push_back(mk("bypass_x4",    1, 2'b01, 4,  0, 32'h55,        0,             0, 0,  4,  4, 32'h55,        32'h55,        2'b00, 0, 0));
    vecs.push_back(mk("read_x4",      1, 2'b00, 0,  0, 0,             0,             0, 0,  4,  0, 32'h55,        0,             2'b00, 0, 32'h55));
    vecs.push_back(mk("alloc_10",     1, 2'b00, 0,  0, 0,             0,             1, 10, 10, 0, 0,             0,             2'b00, 0, 0));
    vecs.push_back(mk("busy_10",      1, 2'b00, 0,  0, 0,             0,             0, 0,  10, 0, 0,             0,             2'b01, 1, 0));
    vecs.push_back(mk("alloc_wb_10",  1, 2'b01, 10, 0, 32'h123,       0,             1, 10, 10, 10, 32'h123,      32'h123,       2'b11, 1, 0));
    vecs.push_back(mk("still_busy10", 1, 2'b00, 0,  0, 0,             0,             0, 0,  10, 0, 32'h123,       0,             2'b01, 1, 32'h123));
    vecs.push_back(mk("wb_10",        1, 2'b01, 10, 0, 32'h456,       0,             0, 0,  10, 0, 32'h456,       0,             2'b00, 1, 32'h123));
    vecs.push_back(mk("idle_10",      1, 2'b00, 0,  0, 0,             0,             0, 0,  10, 0, 32'h456,       0,             2'b00, 0, 32'h456));
    vecs.push_back(mk("alloc_x0",     1, 2'b00, 0,  0, 0,             0,             1, 0,  0, 10, 0,             32'h456,       2'b00, 0, 0));
    vecs.push_back(mk("after_x0",     1, 2'b00, 0,  0, 0,             0,             0, 0,  0, 10, 0,             32'h456,       2'b00, 0, 0));
    vecs.push_back(mk("wr_alloc_x2",  1, 2'b01, 2,  0, 32'h77,        0,             1, 2,  2,  3, 32'h77,        32'h1111_2222, 2'b01, 0, 0));
    vecs.push_back(mk("alloc_x3",     1, 2'b00, 0,  0, 0,             0,             1, 3,  2,  3, 32'h77,        32'h1111_2222, 2'b01, 1, 32'h77));
    vecs.push_back(mk("cnt_2",        1, 2'b00, 0,  0, 0,             0,             0, 0,  2,  3, 32'h77,        32'h1111_2222, 2'b11, 2, 32'h77));
    vecs.push_back(mk("reset_mid",    0, 2'b01, 2,  0, 32'h99,        0,             1, 5,  2,  3, 32'h77,        32'h1111_2222, 2'b11, 2, 32'h77));
    vecs.push_back(mk("post_reset",   1, 2'b00, 0,  0, 0,             0,             0, 0,  2,  3, 0,             0,             2'b00, 0, 0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Fill every allocatable register; count must stop at NUM_REGS-1.
    for (int r = 1; r < 32; r++) begin
      run_vec(mk("fill", 1, 2'b00, 0, 0, 0, 0, 1, 5'(r), 5'(r), 0, 0, 0, 2'b00, 6'(r - 1), 0));
    end
    run_vec(mk("fill_alloc_x0", 1, 2'b00, 0, 0, 0, 0, 1, 0, 31, 1, 0, 0, 2'b11, 31, 0));
    run_vec(mk("fill_full", 1, 2'b00, 0, 0, 0, 0, 0, 0, 31, 1, 0, 0, 2'b11, 31, 0));

    // Release two per cycle through both write ports; the last pair hits x0.
    for (int i = 0; i < 16; i++) begin
      logic [4:0]  a0, a1;
      logic [31:0] d1;
      a0 = 5'(2 * i + 1);
      a1 = 5'(2 * i + 2);
      d1 = (a1 == 5'd0) ? 32'd0 : 32'h100 + 32'(a1);
      run_vec(mk("release", 1, 2'b11, a0, a1, 32'h100 + 32'(a0), 32'h100 + 32'(a1), 0, 0,
                 a0, a1, 32'h100 + 32'(a0), d1, 2'b00, 6'(31 - 2 * i), 0));
    end
    run_vec(mk("released", 1, 2'b00, 0, 0, 0, 0, 0, 0, 31, 0, 32'h11F, 0, 2'b00, 0, 32'h11F));

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the single-write, dual-read integer regfile.
- Provides NUM_RD asynchronous read ports and NUM_WR synchronous write ports, with optional same-cycle write-to-read bypass.
- Per-register busy scoreboard: the issue stage allocates a destination register and writeback releases it.
- Sits between decode/issue and writeback in the pipelined/dual-issue core.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers; power of two, >= 2.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and never busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching reads.

Ports (AW = $clog2(NUM_REGS), CW = $clog2(NUM_REGS+1)):
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  reset, synchronous, active-low.
- i_rs_addr  in  NUM_RD x AW  read addresses.
- o_rs_data  out  NUM_RD x DATA_W  read data.
- o_rs_busy  out  NUM_RD  scoreboard busy bit for each read address.
- i_rd_wren  in  NUM_WR  write enables.
- i_rd_addr  in  NUM_WR x AW  write addresses.
- i_rd_data  in  NUM_WR x DATA_W  write data.
- i_alloc_en  in  1  mark i_alloc_addr busy.
- i_alloc_addr  in  AW  register to allocate.
- o_busy_cnt  out  CW  registered count of busy registers.

Behaviour:
- Reset (i_reset_n low at a rising edge):
  - all registers <= 0, all busy bits <= 0, o_busy_cnt <= 0;
  - all writes and allocs in that cycle are ignored;
  - bypass is disabled while i_reset_n is low, so reads return stored values only.
- Write (i_rd_wren[k] high at an edge): reg[i_rd_addr[k]] <= i_rd_data[k]. Latency is 1 cycle to stored state.
- Write collision (two enabled ports with the same address): the highest port index wins for data.
- Register 0 when ZERO_REG=1:
  - writes are dropped and allocs are dropped;
  - reads return 0 and o_rs_busy is 0, with or without bypass.
- Read: combinational from i_rs_addr, no clock latency.
- Bypass, when BYPASS=1 and an enabled write port matches i_rs_addr[j] this cycle:
  - o_rs_data[j] = i_rd_data of the highest matching port index;
  - o_rs_busy[j] = 0, unless i_alloc_en is high with i_alloc_addr == i_rs_addr[j], in which case it is 1.
- Without bypass: o_rs_data = stored value and o_rs_busy = stored busy bit.
- Scoreboard next state per register r:
  - set if alloc hits r;
  - else clear if any enabled write hits r;
  - else hold.
  - Alloc beats writeback on the same register in the same cycle: the new producer is outstanding.
- Alloc of an already-busy register: stays busy; no error is flagged.
- Write to a non-busy register: data is written; busy stays 0.
- o_busy_cnt: registered popcount of the next busy vector, so it equals the number of set busy bits after the edge. Range 0..NUM_REGS (or NUM_REGS-1 when ZERO_REG=1); never wraps.
- Out-of-range addresses cannot occur because NUM_REGS is a power of two.

Decomposition:
- regfile_pkg holds:
  - function rf_aw(n) returning $clog2(n);
  - typedef rf_addr_t for the default AW=5;
  - typedef rf_data_t for the default DATA_W=32;
  - localparam RF_ZERO_ADDR = 0.
- Sub-module regfile_scoreboard:
  - owns the busy vector, the alloc/clear priority and o_busy_cnt;
  - takes the write enables/addresses and the alloc pair;
  - exports the busy vector and the next-state vector for bypass.
- The data array, write priority and read/bypass muxing stay in regfile_mp.

Test Plan:
- Reset then read: i_reset_n=0 for 1 edge, then i_rs_addr={5,31} -> o_rs_data={0,0}, o_rs_busy=0, o_busy_cnt=0.
- Dual write, then read: port0 writes x3=0x1111_2222 and port1 writes x7=0xDEAD_BEEF in one cycle; next cycle read {3,7} -> {0x11112222, 0xDEADBEEF}.
- Collision and zero register:
  - both ports write x9 (port0=0xA, port1=0xB) -> next cycle x9 reads 0xB;
  - write x0=0xFFFF_FFFF -> x0 reads 0.
- Bypass (BYPASS=1): in the same cycle write x4=0x55 and read x4 -> o_rs_data=0x55 combinationally, while the stored value is still old. With BYPASS=0 the same stimulus returns the old value.
- Scoreboard sequence:
  - alloc x10 -> o_rs_busy for x10 = 1, o_busy_cnt=1;
  - in one cycle, alloc x10 and write x10 -> x10 stays busy, cnt=1;
  - write x10 alone -> busy 0, cnt=0;
  - alloc x0 -> cnt remains 0.
- Reset mid-operation: x2=0x77 written and x2, x3 allocated (cnt=2); assert i_reset_n=0 together with a write of x2=0x99 -> next cycle x2 reads 0, all busy bits 0, cnt=0, and the write is discarded.
